// File: rtl/dct_row_packer.sv
// Packs a serial pixel stream into 64-bit rows for the 8x8 transpose RAM,
// then sequences the eight column reads and flags each column on the RAM output.
module dct_row_packer #(
    parameter int BLK_N = 8,
    parameter int PIX_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIX_W-1:0]       pix_in,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic                   blk_abort,
    input  logic                   col_ready,
    output logic                   ram_rnw,
    output logic                   ram_din_valid,
    output logic [BLK_N-1:0]       ram_be,
    output logic [2:0]             ram_wa,
    output logic [2:0]             ram_ra,
    output logic [BLK_N*PIX_W-1:0] ram_di,
    output logic                   col_valid,
    output logic [2:0]             col_idx,
    output logic                   blk_done
);

    localparam int ROW_W = BLK_N * PIX_W;
    localparam logic [2:0] LAST = 3'(BLK_N - 1);

    typedef enum logic [1:0] {FILL, WLAST, DRAIN} state_t;

    state_t state, next_state;

    logic [2:0]             byte_cnt;
    logic [2:0]             row_cnt;
    logic [2:0]             col_cnt;
    logic [ROW_W-PIX_W-1:0] row_buf;
    logic                   rd_issued;

    logic accept;
    logic row_end;
    logic issue;
    logic drain_done;

    // drain_done marks the cycle column 7's address is on the RAM; no new read may start then.
    always_comb begin
        accept     = (state == FILL) && pix_valid && pix_ready;
        row_end    = accept && (byte_cnt == LAST);
        drain_done = (state == DRAIN) && rd_issued && (ram_ra == LAST);
        issue      = (state == DRAIN) && col_ready && !drain_done;

        next_state = state;
        case (state)
            FILL:    if (row_end && (row_cnt == LAST)) next_state = WLAST;
            WLAST:   next_state = DRAIN;
            DRAIN:   if (drain_done) next_state = FILL;
            default: next_state = FILL;
        endcase
        if (blk_abort) next_state = FILL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt      <= '0;
            row_cnt       <= '0;
            col_cnt       <= '0;
            row_buf       <= '0;
            rd_issued     <= 1'b0;
            pix_ready     <= 1'b0;
            ram_rnw       <= 1'b1;
            ram_din_valid <= 1'b0;
            ram_be        <= '1;
            ram_wa        <= '0;
            ram_ra        <= '0;
            ram_di        <= '0;
            col_valid     <= 1'b0;
            col_idx       <= '0;
            blk_done      <= 1'b0;
        end else begin
            pix_ready     <= (next_state == FILL);
            ram_rnw       <= (next_state != DRAIN);
            ram_din_valid <= row_end && !blk_abort;
            ram_be        <= (row_end && !blk_abort) ? '0 : '1;
            rd_issued     <= issue && !blk_abort;
            col_valid     <= rd_issued && !blk_abort;
            blk_done      <= rd_issued && (ram_ra == LAST) && !blk_abort;

            // Oldest pixel shifts up so the first pixel of a row lands in the top byte.
            if (accept) row_buf <= {row_buf[ROW_W-2*PIX_W-1:0], pix_in};

            if (row_end) begin
                ram_di <= {row_buf, pix_in};
                ram_wa <= row_cnt;
            end

            if (rd_issued) col_idx <= ram_ra;

            if (blk_abort) begin
                byte_cnt <= '0;
                row_cnt  <= '0;
                col_cnt  <= '0;
                ram_ra   <= '0;
            end else begin
                if (accept)  byte_cnt <= byte_cnt + 3'd1;
                if (row_end) row_cnt  <= row_cnt + 3'd1;
                if (issue) begin
                    ram_ra  <= col_cnt;
                    col_cnt <= col_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_row_packer.sv
// Randomized self-checking bench for dct_row_packer with a transpose RAM model
// and a block-level reference model of the fill/drain sequence.
module tb_dct_row_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic        blk_abort;
    logic        col_ready;
    logic        ram_rnw;
    logic        ram_din_valid;
    logic [7:0]  ram_be;
    logic [2:0]  ram_wa;
    logic [2:0]  ram_ra;
    logic [63:0] ram_di;
    logic        col_valid;
    logic [2:0]  col_idx;
    logic        blk_done;

    dct_row_packer dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .blk_abort(blk_abort), .col_ready(col_ready),
        .ram_rnw(ram_rnw), .ram_din_valid(ram_din_valid), .ram_be(ram_be),
        .ram_wa(ram_wa), .ram_ra(ram_ra), .ram_di(ram_di), .col_valid(col_valid),
        .col_idx(col_idx), .blk_done(blk_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Transpose RAM: byte-enabled row writes, registered column reads.
    logic [63:0] mem [8];
    logic [63:0] data_out = '0;

    always @(posedge clk) begin
        logic [63:0] col;
        col = '0;
        for (int r = 0; r < 8; r++) col[63-8*r -: 8] = mem[r][63-8*ram_ra -: 8];
        if (ram_din_valid)
            for (int b = 0; b < 8; b++)
                if (!ram_be[b]) mem[ram_wa][8*b +: 8] <= ram_di[8*b +: 8];
        if (!ram_rnw) data_out <= col;
    end

    // Reference model: pixels of the current block, how many columns were requested,
    // and the two-cycle latency from a sampled col_ready to its column.
    logic [7:0]  blk [64];
    int          filled = 0, drain_delay = 0, issued = 0;
    bit          st1_v = 0, cv_v = 0, exp_wr = 0, exp_ready = 0, exp_done = 0;
    int          st1_idx = 0, cv_idx = 0;
    logic [2:0]  exp_wa = '0;
    logic [63:0] exp_di = '0, exp_col = '0;

    task automatic clearModel(input bit ready);
        filled = 0; drain_delay = 0; issued = 0;
        st1_v = 0; cv_v = 0; exp_wr = 0; exp_done = 0;
        exp_ready = ready;
    endtask

    always @(posedge clk) begin
        if (rst) clearModel(0);
        else if (blk_abort) clearModel(1);
        else begin
            cv_v   = st1_v;
            cv_idx = st1_idx;
            st1_v  = 0;
            exp_wr = 0;
            if (filled < 64) begin
                if (pix_valid && exp_ready) begin
                    blk[filled] = pix_in;
                    filled++;
                    if (filled % 8 == 0) begin
                        exp_wr = 1;
                        exp_wa = 3'(filled / 8 - 1);
                        for (int k = 0; k < 8; k++) exp_di[63-8*k -: 8] = blk[filled-8+k];
                    end
                    if (filled == 64) drain_delay = 1;
                end
            end else if (drain_delay > 0) drain_delay--;
            else if (col_ready && issued < 8) begin
                st1_v   = 1;
                st1_idx = issued;
                issued++;
            end
            if (cv_v) for (int r = 0; r < 8; r++) exp_col[63-8*r -: 8] = blk[8*r+cv_idx];
            exp_done = cv_v && (cv_idx == 7);
            if (exp_done) begin
                filled = 0;
                issued = 0;
            end
            exp_ready = (filled < 64);
        end
    end

    logic [63:0] wr_log[$];
    logic [63:0] col_log[$];
    int done_cnt = 0;
    int cv_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("pix_ready", 64'(pix_ready), 64'(exp_ready));
            checkOutput("ram_rnw", 64'(ram_rnw), 64'(!(filled == 64 && drain_delay == 0)));
            checkOutput("din_valid", 64'(ram_din_valid), 64'(exp_wr));
            if (exp_wr) begin
                checkOutput("ram_wa", 64'(ram_wa), 64'(exp_wa));
                checkOutput("ram_di", ram_di, exp_di);
                checkOutput("ram_be_wr", 64'(ram_be), 64'h00);
            end else checkOutput("ram_be_idle", 64'(ram_be), 64'hFF);
            checkOutput("col_valid", 64'(col_valid), 64'(cv_v));
            if (cv_v) begin
                checkOutput("col_idx", 64'(col_idx), 64'(cv_idx));
                checkOutput("col_data", data_out, exp_col);
            end
            checkOutput("blk_done", 64'(blk_done), 64'(exp_done));
            if (st1_v) checkOutput("ram_ra", 64'(ram_ra), 64'(st1_idx));
            if (ram_din_valid) wr_log.push_back(ram_di);
            if (col_valid) begin
                col_log.push_back(data_out);
                cv_cnt++;
            end
            if (blk_done) done_cnt++;
        end
    end

    function automatic logic [63:0] rampCol(input int c);
        logic [63:0] v;
        for (int r = 0; r < 8; r++) v[63-8*r -: 8] = 8'(8*r + c);
        return v;
    endfunction

    // mode 0: back-to-back ramp, 1: valid toggling ramp, 2: random valid and data.
    task automatic applyStimulus(input int n, input int mode, output int cycles);
        int sent = 0;
        bit tog = 1;
        bit acc;
        cycles = 0;
        while (sent < n && cycles < 2000) begin
            pix_valid = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            pix_in    = (mode == 2) ? 8'($urandom) : 8'(sent);
            tog       = !tog;
            acc       = pix_valid && pix_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            cycles++;
        end
        pix_valid = 1'b0;
        if (sent != n) checkOutput("pix_timeout", 64'(sent), 64'(n));
    endtask

    task automatic drainBlock(input int mode);
        int cyc = 0;
        int start = done_cnt;
        while (done_cnt == start && cyc < 300) begin
            col_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            cyc++;
        end
        col_ready = 1'b0;
        checkOutput("drain_blocks", 64'(done_cnt - start), 64'd1);
    endtask

    initial begin
        int cyc;
        int start;
        rst = 1'b1; pix_in = '0; pix_valid = 0; blk_abort = 0; col_ready = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_pix_ready", 64'(pix_ready), 64'd0);
        checkOutput("rst_rnw", 64'(ram_rnw), 64'd1);
        checkOutput("rst_be", 64'(ram_be), 64'hFF);
        checkOutput("rst_di", ram_di, 64'd0);
        checkOutput("rst_col_valid", 64'(col_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("ready_after_rst", 64'(pix_ready), 64'd1);

        $display("[TB] back-to-back ramp block");
        wr_log.delete(); col_log.delete();
        applyStimulus(64, 0, cyc);
        checkOutput("no_stall_cycles", 64'(cyc), 64'd64);
        drainBlock(0);
        checkOutput("row_count", 64'(wr_log.size()), 64'd8);
        checkOutput("row0", wr_log[0], 64'h0001020304050607);
        checkOutput("row7", wr_log[7], 64'h38393A3B3C3D3E3F);
        checkOutput("col_count", 64'(col_log.size()), 64'd8);
        checkOutput("col0", col_log[0], 64'h0008101820283038);

        $display("[TB] toggling valid ramp block");
        col_log.delete();
        applyStimulus(64, 1, cyc);
        drainBlock(0);
        for (int c = 0; c < 8; c++) checkOutput("toggle_col", col_log[c], rampCol(c));

        $display("[TB] col_ready pattern 1,0,0,1");
        applyStimulus(64, 2, cyc);
        repeat (4) @(posedge clk);
        #1;
        start = cv_cnt;
        foreach (cyc_pat[i]) begin
            col_ready = cyc_pat[i];
            @(posedge clk);
            #1;
        end
        col_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("pattern_pulses", 64'(cv_cnt - start), 64'd2);
        drainBlock(1);

        $display("[TB] abort during fill and during drain");
        applyStimulus(43, 2, cyc);
        pix_valid = 1'b1; pix_in = 8'hAA; blk_abort = 1'b1;
        @(posedge clk);
        #1;
        blk_abort = 1'b0; pix_valid = 1'b0;
        checkOutput("abort_ready", 64'(pix_ready), 64'd1);
        applyStimulus(64, 2, cyc);
        drainBlock(1);
        applyStimulus(64, 0, cyc);
        col_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        start = done_cnt;
        blk_abort = 1'b1;
        @(posedge clk);
        #1;
        blk_abort = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        col_ready = 1'b0;
        checkOutput("abort_no_done", 64'(done_cnt - start), 64'd0);
        applyStimulus(64, 2, cyc);
        drainBlock(1);

        $display("[TB] reset during drain");
        applyStimulus(64, 0, cyc);
        col_ready = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(col_valid && col_idx == 3'd4) && cyc < 100);
        checkOutput("reach_col4", 64'(col_idx), 64'd4);
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_pix_ready", 64'(pix_ready), 64'd0);
        checkOutput("arst_col_valid", 64'(col_valid), 64'd0);
        checkOutput("arst_rnw", 64'(ram_rnw), 64'd1);
        checkOutput("arst_ra", 64'(ram_ra), 64'd0);
        checkOutput("arst_col_idx", 64'(col_idx), 64'd0);
        checkOutput("arst_blk_done", 64'(blk_done), 64'd0);
        repeat (4) begin
            @(negedge clk);
            checkOutput("rst_hold_col_valid", 64'(col_valid), 64'd0);
        end
        @(posedge clk);
        #2 rst = 1'b0; col_ready = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(64, 2, cyc);
        drainBlock(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    bit cyc_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

endmodule

// File: doc/dct_row_packer.md
Name: dct_row_packer

Overview:
Upstream feeder for the 8x8 transpose RAM in the DCTQ datapath. Accepts a serial 8-bit pixel stream with a valid/ready handshake and packs 8 pixels into a 64-bit row. Writes 8 rows to the transpose RAM, then sequences 8 column reads and flags each column as it appears on the RAM's registered output. Alternates FILL and DRAIN phases per 8x8 block.

Parameters:
BLK_N, 8, rows per block, columns per block and pixels per row; only 8 is supported.
PIX_W, 8, pixel width in bits; ram_di width is BLK_N*PIX_W = 64.

Ports:
clk  input  1  single clock; also drives the RAM's pci_clk and clk.
rst  input  1  asynchronous active-high reset.
pix_in  input  8  pixel data.
pix_valid  input  1  pixel_in is valid.
pix_ready  output  1  packer can accept a pixel.
blk_abort  input  1  synchronous abort: discard current block and return to FILL.
col_ready  input  1  downstream can take a column two cycles later.
ram_rnw  output  1  1 = write phase / hold RAM output, 0 = column read.
ram_din_valid  output  1  RAM write strobe.
ram_be  output  8  active-low byte enables; 8'h00 = write all bytes.
ram_wa  output  3  RAM write row address.
ram_ra  output  3  RAM column read address.
ram_di  output  64  packed row; the first pixel of a row is in [63:56].
col_valid  output  1  RAM data_out holds column col_idx this cycle.
col_idx  output  3  index of the column on RAM data_out.
blk_done  output  1  one-cycle pulse with the column-7 col_valid.

Behaviour:
- Every output is registered. Reset values:
  - pix_ready=0, ram_rnw=1, ram_din_valid=0, ram_be=8'hFF, ram_wa=0, ram_ra=0, ram_di=0.
  - col_valid=0, col_idx=0, blk_done=0.
  - Internal state: FILL, byte_cnt=0, row_cnt=0, col_cnt=0.
  - pix_ready rises to 1 on the first clk edge after rst deasserts.
- Reset asserted mid-block: all state clears immediately. Partial rows and written rows are abandoned, and RAM contents are don't-care.
- States: FILL, WLAST, DRAIN.
- FILL:
  - pix_ready=1, ram_rnw=1.
  - A pixel is accepted when pix_valid&pix_ready. It goes into shift byte lane (7-byte_cnt), and byte_cnt increments.
  - On acceptance with byte_cnt=7, the next cycle presents the write with no bubble in pixel acceptance:
    - ram_di = {7 held bytes, pix_in}, ram_wa = row_cnt, ram_be = 8'h00, ram_din_valid = 1, for exactly one cycle.
    - row_cnt increments and byte_cnt wraps to 0.
  - If that row was row_cnt=7, the FSM goes to WLAST and pix_ready drops to 0 in the same cycle the write is presented.
  - Outside write cycles: ram_din_valid=0 and ram_be=8'hFF.
- WLAST:
  - One cycle carrying the row-7 write.
  - Then ram_rnw=0 and the FSM enters DRAIN with col_cnt=0.
- DRAIN:
  - pix_ready=0, ram_rnw=0, ram_be=8'hFF, ram_din_valid=0.
  - In a cycle where col_ready=1, ram_ra=col_cnt is presented on the following cycle and col_cnt increments.
  - RAM latency is 1 clk, so col_valid=1 and col_idx=that ra one cycle after ra is presented (2 cycles after col_ready was sampled).
  - col_ready=0 stalls col_cnt; ram_ra holds and col_valid is not asserted.
  - After column 7 is issued, ram_rnw returns to 1 and the FSM returns to FILL with row_cnt=0.
  - pix_ready=1 in the same cycle col_valid/blk_done for column 7 is asserted.
- Downstream must consume every col_valid; there is no backpressure after col_ready is sampled.
- blk_abort=1 in any state:
  - Next cycle is FILL with all counters 0.
  - ram_din_valid=0, any pending col_valid is suppressed, and no blk_done is issued.
  - blk_abort outranks a simultaneous pixel accept (that pixel is dropped) and col_ready.
- The counters wrap 7->0 naturally; no other wrap states exist.

Test Plan:
- Reset, then 64 back-to-back pixels with value = 8*row+col -> rows written on 8 cycles with no stall.
  - Row 0 ram_di=64'h0001020304050607.
  - Row 7 ram_di=64'h38393A3B3C3D3E3F, ram_wa=7.
  - ram_be=8'h00 only on write cycles.
- Same block, col_ready held 1 -> ram_ra 0..7 on consecutive cycles, col_valid one cycle later with col_idx 0..7.
  - Column 0 data_out=64'h0008101820283038.
  - blk_done coincides with col_idx=7.
  - pix_ready=1 on that same cycle.
- pix_valid toggling 1/0 every cycle in FILL -> identical RAM contents and columns as the first test; writes only on the cycle after the 8th byte of each row is accepted.
- DRAIN with col_ready pattern 1,0,0,1 -> only 2 col_valid pulses (idx 0 and 1), spaced to match, and col_cnt holds while col_ready=0.
- blk_abort asserted after 3 pixels of row 5 -> FILL with row_cnt=0 and byte_cnt=0. The next 64 pixels produce correct columns, and no spurious blk_done occurs.
- Asynchronous rst asserted during DRAIN at col_idx=4 -> outputs take reset values within the same cycle, and col_valid=0 with no further reads.
